adder_share_ctrl: RTL and testbench

Shared-adder controller. Two requesters share one N-bit ripple-carry adder slice, and each request is a WIDTH = N*CHUNKS-bit addition. The block arbitrates round-robin between the requesters and sequences the slice over CHUNKS cycles, least-significant chunk first, passing the carry between chunks in a register. It returns the full-width sum and carry-out through a valid/ready response port. It sits between the two operand producers and the result consumer, so a 64-bit add costs a 16-bit adder's area.

---
 rtl/adder_share_ctrl.sv | 136 +++++++++++++
 tb/tb_adder_share_ctrl.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_share_ctrl.sv
// adder_share_ctrl
//   Two requesters share a single N-bit ripple-carry slice. Each request is a
//   WIDTH = N*CHUNKS bit addition, sequenced LS chunk first over CHUNKS
//   cycles with the inter-chunk carry held in a 1-bit register. Arbitration
//   between the requesters is round-robin.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   reqX_valid / reqX_ready    request handshake for requester X (0 or 1)
//   reqX_a, reqX_b, reqX_cin   operands and carry-in for requester X
//   resp_valid / resp_ready    response handshake
//   resp_id                    requester that owns the response
//   resp_sum, resp_cout        a + b + cin (mod 2^WIDTH) and carry-out
//   busy                       operation in progress (ADD or DONE)
module adder_share_ctrl #(
    parameter int unsigned N      = 16,
    parameter int unsigned CHUNKS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [N*CHUNKS-1:0]   req0_a,
    input  logic [N*CHUNKS-1:0]   req0_b,
    input  logic                  req0_cin,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [N*CHUNKS-1:0]   req1_a,
    input  logic [N*CHUNKS-1:0]   req1_b,
    input  logic                  req1_cin,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic                  resp_id,
    output logic [N*CHUNKS-1:0]   resp_sum,
    output logic                  resp_cout,
    output logic                  busy
);

    localparam int unsigned WIDTH = N * CHUNKS;
    localparam int unsigned KW    = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(CHUNKS - 1);

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, b_q, sum_q;
    logic [KW-1:0]     k_q;
    logic              carry_q;
    logic              cout_q;
    logic              id_q;
    logic              last_grant_q;

    logic              grant0, grant1, accept, last_chunk;
    logic [N-1:0]      a_chunk, b_chunk;
    logic [N:0]        chunk_sum;

    // Round-robin grant: a lone requester always wins; on contention the
    // requester not granted last time wins.
    always_comb begin
        grant0     = req0_valid && (!req1_valid || last_grant_q);
        grant1     = req1_valid && (!req0_valid || !last_grant_q);
        accept     = (state_q == IDLE) && (grant0 || grant1);
        last_chunk = (k_q == K_LAST);
        a_chunk    = a_q[k_q*N +: N];
        b_chunk    = b_q[k_q*N +: N];
        chunk_sum  = {1'b0, a_chunk} + {1'b0, b_chunk} + {{N{1'b0}}, carry_q};
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept)     state_d = ADD;
            ADD:     if (last_chunk) state_d = DONE;
            DONE:    if (resp_ready) state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    // Outputs. Readys are gated by rst_n so valids are ignored while reset
    // is asserted even though the state register already reads IDLE.
    always_comb begin
        req0_ready = rst_n && (state_q == IDLE) && grant0;
        req1_ready = rst_n && (state_q == IDLE) && grant1;
        resp_valid = (state_q == DONE);
        busy       = (state_q != IDLE);
        resp_id    = id_q;
        resp_sum   = sum_q;
        resp_cout  = cout_q;
    end

    // Operand capture and chunked datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q          <= '0;
            b_q          <= '0;
            sum_q        <= '0;
            k_q          <= '0;
            carry_q      <= 1'b0;
            cout_q       <= 1'b0;
            id_q         <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        id_q         <= grant1;
                        last_grant_q <= grant1;
                        a_q          <= grant1 ? req1_a   : req0_a;
                        b_q          <= grant1 ? req1_b   : req0_b;
                        carry_q      <= grant1 ? req1_cin : req0_cin;
                        k_q          <= '0;
                    end
                end
                ADD: begin
                    sum_q[k_q*N +: N] <= chunk_sum[N-1:0];
                    carry_q           <= chunk_sum[N];
                    if (last_chunk) cout_q <= chunk_sum[N];
                    else            k_q    <= k_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_share_ctrl.sv
module tb_adder_share_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req0_cin;
    logic [63:0] req0_a, req0_b;
    logic        req1_valid, req1_ready, req1_cin;
    logic [63:0] req1_a, req1_b;
    logic        resp_valid, resp_ready, resp_id, resp_cout, busy;
    logic [63:0] resp_sum;

    typedef struct packed {
        logic        id;
        logic        cout;
        logic [63:0] sum;
    } exp_t;

    typedef struct packed {
        logic        id;
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        logic [63:0] sum;
        logic        cout;
    } vec_t;

    exp_t sb[$];
    int   vectors = 0;
    int   errors  = 0;

    adder_share_ctrl #(.N(16), .CHUNKS(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_cin   (req0_cin),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_cin   (req1_cin),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_sum   (resp_sum),
        .resp_cout  (resp_cout),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
        $fatal(1, "watchdog");
    end

    function automatic exp_t model(input logic id, input logic [63:0] a, input logic [63:0] b,
                                   input logic cin);
        logic [64:0] r;
        exp_t        e;
        r      = {1'b0, a} + {1'b0, b} + {64'd0, cin};
        e.id   = id;
        e.cout = r[64];
        e.sum  = r[63:0];
        return e;
    endfunction

    // Drives a request, waits (bounded) for its ready, optionally pushes the
    // model result. Starts and ends 1 time unit after a rising edge.
    task automatic send(input logic id, input logic [63:0] a, input logic [63:0] b,
                        input logic cin, input logic push_model, output bit to);
        if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_cin = cin; end
        else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_cin = cin; end
        to = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (id ? req1_ready : req0_ready) begin
                to = 1'b0;
                break;
            end
        end
        if (!to && push_model) sb.push_back(model(id, a, b, cin));
        @(posedge clk); #1;
        if (id) req1_valid = 1'b0;
        else    req0_valid = 1'b0;
    endtask

    // Waits (bounded) for resp_valid; returns at the negedge where it is seen.
    task automatic await_resp(output int cyc, output bit to);
        cyc = 0;
        to  = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            cyc++;
            if (resp_valid) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n      = 1'b1;
        resp_ready = 1'b1;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_cin = 1'b0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_cin = 1'b0;
        #2 rst_n = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        @(negedge clk);
        vectors++;
        if ({req0_ready, req1_ready, resp_valid, resp_id, resp_cout, busy, resp_sum} !== 70'd0) begin
            errors++;
            $display("FAIL reset_state: r0=%b r1=%b rv=%b id=%b cout=%b busy=%b sum=%h, required all 0",
                     req0_ready, req1_ready, resp_valid, resp_id, resp_cout, busy, resp_sum);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic test_arith_vectors();
        vec_t tbl[3];
        bit   to;
        int   cyc;
        exp_t e;
        tbl[0] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 1'b1};
        tbl[1] = '{1'b0, 64'h0000_7FFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0,
                   64'h0000_8000_0001_0000, 1'b0};
        tbl[2] = '{1'b1, 64'd0, 64'd0, 1'b1, 64'd1, 1'b0};
        resp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send(tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].cin, 1'b0, to);
            vectors++;
            if (to) begin
                errors++;
                $display("FAIL vec%0d_accept: ready never seen, required within 50 cycles", i);
                continue;
            end
            sb.push_back('{tbl[i].id, tbl[i].cout, tbl[i].sum});
            await_resp(cyc, to);
            vectors++;
            if (to || cyc != 5) begin
                errors++;
                $display("FAIL vec%0d_latency: resp_valid after %0d cycles (timeout=%0b), required 5", i, cyc, to);
            end
            if (!to) begin
                e = sb.pop_front();
                vectors++;
                if ({resp_id, resp_cout, resp_sum} !== {e.id, e.cout, e.sum}) begin
                    errors++;
                    $display("FAIL vec%0d_result: id=%b cout=%b sum=%h, required id=%b cout=%b sum=%h",
                             i, resp_id, resp_cout, resp_sum, e.id, e.cout, e.sum);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random_ops();
        bit          to;
        int          cyc;
        exp_t        e;
        logic [63:0] a, b;
        resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            send(logic'(i % 2), a, b, logic'($urandom_range(0, 1)), 1'b1, to);
            await_resp(cyc, to);
            vectors++;
            if (to || cyc != 5) begin
                errors++;
                $display("FAIL rand%0d_latency: %0d cycles (timeout=%0b), required 5", i, cyc, to);
            end
            if (!to && sb.size() > 0) begin
                e = sb.pop_front();
                vectors++;
                if ({resp_id, resp_cout, resp_sum} !== {e.id, e.cout, e.sum}) begin
                    errors++;
                    $display("FAIL rand%0d_result: id=%b cout=%b sum=%h, required id=%b cout=%b sum=%h",
                             i, resp_id, resp_cout, resp_sum, e.id, e.cout, e.sum);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_contention();
        logic [63:0] a0[2], b0[2];
        logic        c0[2];
        logic [63:0] a1, b1;
        logic        c1;
        int          idx0, n, nresp;
        logic [2:0]  ord;
        logic        s0, s1, rv, prev0, prev1;
        exp_t        e;
        a0[0] = 64'h1234_5678_9ABC_DEF0; b0[0] = 64'h0FED_CBA9_8765_4321; c0[0] = 1'b1;
        a0[1] = 64'hFFFF_0000_FFFF_0000; b0[1] = 64'h0001_0000_0001_0000; c0[1] = 1'b0;
        a1    = 64'hDEAD_BEEF_0000_0001; b1    = 64'h2152_4110_FFFF_FFFF; c1    = 1'b0;
        apply_reset();
        resp_ready = 1'b1;
        idx0 = 0; n = 0; nresp = 0; ord = 3'b111; prev0 = 1'b0; prev1 = 1'b0;
        req0_a = a0[0]; req0_b = b0[0]; req0_cin = c0[0]; req0_valid = 1'b1;
        req1_a = a1;    req1_b = b1;    req1_cin = c1;    req1_valid = 1'b1;
        for (int cyc = 0; cyc < 100 && nresp < 3; cyc++) begin
            @(negedge clk);
            s0 = req0_ready; s1 = req1_ready; rv = resp_valid;
            vectors++;
            if ((s0 && s1) || (s0 && prev0) || (s1 && prev1)) begin
                errors++;
                $display("FAIL contention_ready_pulse: r0=%b r1=%b prev0=%b prev1=%b, required single one-cycle ready",
                         s0, s1, prev0, prev1);
            end
            if (s0) begin
                if (n < 3) ord[n] = 1'b0;
                n++;
                sb.push_back(model(1'b0, a0[idx0], b0[idx0], c0[idx0]));
            end
            if (s1) begin
                if (n < 3) ord[n] = 1'b1;
                n++;
                sb.push_back(model(1'b1, a1, b1, c1));
            end
            if (rv) begin
                nresp++;
                vectors++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL contention_result: response with empty scoreboard, required none");
                end else begin
                    e = sb.pop_front();
                    if ({resp_id, resp_cout, resp_sum} !== {e.id, e.cout, e.sum}) begin
                        errors++;
                        $display("FAIL contention_result: id=%b cout=%b sum=%h, required id=%b cout=%b sum=%h",
                                 resp_id, resp_cout, resp_sum, e.id, e.cout, e.sum);
                    end
                end
            end
            prev0 = s0; prev1 = s1;
            @(posedge clk); #1;
            if (s0) begin
                idx0++;
                if (idx0 < 2) begin req0_a = a0[idx0]; req0_b = b0[idx0]; req0_cin = c0[idx0]; end
                else req0_valid = 1'b0;
            end
            if (s1) req1_valid = 1'b0;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        vectors++;
        if (nresp != 3 || n != 3 || ord !== 3'b010) begin
            errors++;
            $display("FAIL contention_order: grants=%0d resps=%0d order(bit0 first)=%b, required 3/3 order 0,1,0 (3'b010)",
                     n, nresp, ord);
        end
    endtask

    task automatic test_back_to_back_backpressure();
        bit          to;
        int          cyc;
        exp_t        e;
        logic [63:0] a1, b1;
        a1 = 64'h0F0F_0F0F_F0F0_F0F0;
        b1 = 64'hF0F0_F0F0_0F0F_0F10;
        resp_ready = 1'b0;
        send(1'b0, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0002, 1'b1, 1'b1, to);
        vectors++;
        if (to) begin
            errors++;
            $display("FAIL bp_accept0: ready never seen, required within 50 cycles");
        end
        req1_a = a1; req1_b = b1; req1_cin = 1'b0; req1_valid = 1'b1;
        to = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (resp_valid) begin to = 1'b0; break; end
            vectors++;
            if (req1_ready !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL bp_add_phase: req1_ready=%b busy=%b, required 0/1", req1_ready, busy);
            end
        end
        vectors++;
        if (to || sb.size() == 0) begin
            errors++;
            $display("FAIL bp_resp_timeout: resp_valid=%b sb=%0d, required 1 and 1", resp_valid, sb.size());
            req1_valid = 1'b0;
            resp_ready = 1'b1;
            @(posedge clk); #1;
            return;
        end
        e = sb[0];
        for (int j = 0; j < 4; j++) begin
            if (j > 0) @(negedge clk);
            vectors++;
            if (resp_valid !== 1'b1 || busy !== 1'b1 || req1_ready !== 1'b0 ||
                {resp_id, resp_cout, resp_sum} !== {e.id, e.cout, e.sum}) begin
                errors++;
                $display("FAIL bp_hold%0d: rv=%b busy=%b r1=%b id=%b cout=%b sum=%h, required 1/1/0 id=%b cout=%b sum=%h",
                         j, resp_valid, busy, req1_ready, resp_id, resp_cout, resp_sum, e.id, e.cout, e.sum);
            end
            @(posedge clk); #1;
            if (j == 2) resp_ready = 1'b1;
        end
        void'(sb.pop_front());
        @(negedge clk);
        vectors++;
        if (req1_ready !== 1'b1 || busy !== 1'b0 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_next_accept: r1=%b busy=%b rv=%b, required 1/0/0", req1_ready, busy, resp_valid);
        end
        if (req1_ready) sb.push_back(model(1'b1, a1, b1, 1'b0));
        @(posedge clk); #1;
        req1_valid = 1'b0;
        await_resp(cyc, to);
        vectors++;
        if (to || cyc != 5 || sb.size() == 0) begin
            errors++;
            $display("FAIL bp_second_resp: cycles=%0d timeout=%0b sb=%0d, required 5/0/1", cyc, to, sb.size());
        end else begin
            e = sb.pop_front();
            vectors++;
            if ({resp_id, resp_cout, resp_sum} !== {e.id, e.cout, e.sum}) begin
                errors++;
                $display("FAIL bp_second_result: id=%b cout=%b sum=%h, required id=%b cout=%b sum=%h",
                         resp_id, resp_cout, resp_sum, e.id, e.cout, e.sum);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_op();
        bit   to;
        int   cyc;
        int   spurious;
        exp_t e;
        resp_ready = 1'b1;
        send(1'b0, 64'hAAAA_5555_AAAA_5555, 64'h1111_2222_3333_4444, 1'b1, 1'b0, to);
        @(posedge clk); #1;
        rst_n = 1'b0;
        req1_valid = 1'b1;
        #1;
        vectors++;
        if ({req0_ready, req1_ready, resp_valid, resp_id, resp_cout, busy, resp_sum} !== 70'd0) begin
            errors++;
            $display("FAIL midreset_state: r0=%b r1=%b rv=%b id=%b cout=%b busy=%b sum=%h, required all 0",
                     req0_ready, req1_ready, resp_valid, resp_id, resp_cout, busy, resp_sum);
        end
        @(posedge clk); #1;
        req1_valid = 1'b0;
        rst_n = 1'b1;
        spurious = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (resp_valid || busy) spurious++;
        end
        vectors++;
        if (spurious != 0) begin
            errors++;
            $display("FAIL midreset_no_resp: %0d cycles with resp_valid/busy, required 0", spurious);
        end
        @(posedge clk); #1;
        send(1'b1, 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0, 1'b1, to);
        await_resp(cyc, to);
        vectors++;
        if (to || cyc != 5 || sb.size() == 0) begin
            errors++;
            $display("FAIL midreset_next_op: cycles=%0d timeout=%0b sb=%0d, required 5/0/1", cyc, to, sb.size());
        end else begin
            e = sb.pop_front();
            vectors++;
            if ({resp_id, resp_cout, resp_sum} !== {e.id, e.cout, e.sum}) begin
                errors++;
                $display("FAIL midreset_result: id=%b cout=%b sum=%h, required id=%b cout=%b sum=%h",
                         resp_id, resp_cout, resp_sum, e.id, e.cout, e.sum);
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_arith_vectors();
        test_random_ops();
        test_contention();
        test_back_to_back_backpressure();
        test_reset_mid_op();
        vectors++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
